// File: rtl/cache_mem_arbiter_pkg.sv
// Purpose: shared types and constants for the I/D-cache to block-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: arbiter state encoding, block address/data widths, grant-id encoding.
// The cache modules reuse the width constants and the grant ids.
package cache_mem_arbiter_pkg;

    localparam int MEM_ADDR_W      = 28;    // block address width (cache mem_addr)
    localparam int MEM_DATA_W      = 128;   // 4 x 32-bit words per block
    localparam int MEM_TIMEOUT_DEF = 1023;  // default watchdog limit, 0 disables

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_BUSY  = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Purpose: two-requester round-robin picker (I-cache vs D-cache).
// Latency: purely combinational, decision in the same cycle.
// Backpressure: none; the caller decides when the grant is consumed.
//
// Ports: i_req_i / i_req_d requests, i_last_grant previous winner,
//        o_gnt_vld any request present, o_gnt chosen master.
module rr_arb2
    import cache_mem_arbiter_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  gnt_t i_last_grant,
    output logic o_gnt_vld,
    output gnt_t o_gnt
);

    always_comb begin
        o_gnt_vld = i_req_i | i_req_d;
        o_gnt     = GNT_I;
        if (i_req_i && i_req_d) begin
            // On a tie, the master that did not win last time goes next.
            o_gnt = (i_last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req_d) begin
            o_gnt = GNT_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one 128-bit block memory port between I-cache and D-cache, one transaction at a time.
// Latency: request in IDLE at t -> strobe at t+1; memory latency + 2 cycles to re-arbitration.
// Backpressure: losing master simply keeps requesting; it is never dropped nor acknowledged early.
//
// Ports: I-cache side (i_mem_read/addr in, i_mem_rdata/ready out),
//        D-cache side (d_mem_read/write/addr/wdata in, d_mem_rdata/ready out),
//        memory side (registered mem_read/write/addr/wdata out, mem_rdata/ready in),
//        err_timeout sticky watchdog flag.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err_timeout
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        r_state;
    gnt_t              r_last_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [WD_W-1:0]   r_wdog;
    logic              r_err;

    logic w_i_req;
    logic w_d_req;
    logic w_gnt_vld;
    gnt_t w_gnt;
    logic w_busy;

    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;
    assign w_busy  = (r_state == ST_I_BUSY) || (r_state == ST_D_BUSY);

    rr_arb2 u_rr_arb2 (
        .i_req_i      (w_i_req),
        .i_req_d      (w_d_req),
        .i_last_grant (r_last_grant),
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt        (w_gnt)
    );

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_D;          // so the I-cache wins the first tie
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        if (w_gnt == GNT_I) begin
                            r_state     <= ST_I_BUSY;
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= i_mem_addr;
                        end else begin
                            // Read+write together is illegal; the write wins.
                            r_state     <= ST_D_BUSY;
                            r_mem_read  <= ~d_mem_write;
                            r_mem_write <= d_mem_write;
                            r_mem_addr  <= d_mem_addr;
                            r_mem_wdata <= d_mem_wdata;
                        end
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    if (mem_ready) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_last_grant <= (r_state == ST_I_BUSY) ? GNT_I : GNT_D;
                        r_state      <= ST_RELEASE;
                    end
                end
                // One dead cycle swallows the cache's request still held after ready.
                ST_RELEASE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Watchdog: counts busy cycles without an answer. The flag rises on the
    // same edge the counter reaches TIMEOUT and never aborts the transaction.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else if (w_busy && !mem_ready) begin
            if (r_wdog != WD_MAX) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if ((TIMEOUT != 0) && (r_wdog == WD_LAST)) begin
                r_err <= 1'b1;
            end
        end else begin
            r_wdog <= '0;
        end
    end

    // Completion is forwarded combinationally, only to the granted master.
    assign i_mem_ready = (r_state == ST_I_BUSY) & mem_ready;
    assign d_mem_ready = (r_state == ST_D_BUSY) & mem_ready;
    assign i_mem_rdata = i_mem_ready ? mem_rdata : '0;
    assign d_mem_rdata = d_mem_ready ? mem_rdata : '0;

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign err_timeout = r_err;

endmodule
